pu_io_req_ctrl: RTL and testbench

- One instance per processing unit (PU), sitting between the PU load/store port and the per-PU io_req/io_cmd/io_ack bus. That bus feeds the shared PU memory targets, including the flow packet-descriptor memory.
- Issues at most one outstanding IO request at a time, because each target accepts only one pending request per PU.
- Returns read data to the PU, paces posted writes, and times out lost read acks.

---
 rtl/pu_io_req_ctrl.sv | 142 ++++++++++++++
 tb/tb_pu_io_req_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_io_req_ctrl.sv
// PU IO request controller: one outstanding request per PU, read return,
// posted-write pacing and read-ack timeout.

package pu_io_req_ctrl_pkg;

  localparam int unsigned PU_WIDTH_NBITS = 16;
  localparam int unsigned FID_NBITS      = 8;
  localparam int unsigned IO_ADDR_NBITS  = 16;

  // Command presented to the shared memory targets alongside io_req
  typedef struct packed {
    logic [IO_ADDR_NBITS-1:0]  addr;
    logic [FID_NBITS-1:0]      fid;
    logic                      wr;
    logic [PU_WIDTH_NBITS-1:0] wdata;
  } io_type;

endpackage

module pu_io_req_ctrl
  import pu_io_req_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH_NBITS = PU_WIDTH_NBITS,
  parameter int unsigned WR_GAP      = 3,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_wr,
  input  logic [IO_ADDR_NBITS-1:0] cpu_addr,
  input  logic [FID_NBITS-1:0]     cpu_fid,
  input  logic [WIDTH_NBITS-1:0]   cpu_wdata,
  output logic                     cpu_ready,
  output logic                     cpu_rvalid,
  output logic [WIDTH_NBITS-1:0]   cpu_rdata,
  output logic                     io_req,
  output io_type                   io_cmd,
  input  logic                     io_ack,
  input  logic [WIDTH_NBITS-1:0]   io_ack_data,
  output logic                     err_timeout,
  output logic                     err_stray_ack,
  output logic                     err_proto
);

  localparam int unsigned CNT_NBITS = $clog2(TIMEOUT + 1);
  localparam logic [CNT_NBITS-1:0] CNT_TMO  = CNT_NBITS'(TIMEOUT - 1);
  localparam logic [CNT_NBITS-1:0] CNT_WR   = CNT_NBITS'(WR_GAP - 1);
  localparam logic [CNT_NBITS-1:0] CNT_ZERO = '0;
  localparam logic [CNT_NBITS-1:0] CNT_ONE  = CNT_NBITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_NBITS-1:0] r_cnt;

  logic w_in_idle;
  logic w_in_rd_wait;

  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_in_rd_wait = (r_state == ST_RD_WAIT);

  // Ready is decoded from state so a request can be taken the cycle IDLE is entered
  assign cpu_ready = w_in_idle;

  // Request FSM with registered strobes, command, read data and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      cpu_rvalid    <= 1'b0;
      cpu_rdata     <= '0;
      io_req        <= 1'b0;
      io_cmd        <= '0;
      err_timeout   <= 1'b0;
      err_stray_ack <= 1'b0;
      err_proto     <= 1'b0;
    end else begin
      io_req        <= 1'b0;
      cpu_rvalid    <= 1'b0;
      err_timeout   <= 1'b0;
      err_stray_ack <= io_ack && !w_in_rd_wait;
      err_proto     <= cpu_req && !w_in_idle;

      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            io_req       <= 1'b1;
            io_cmd.addr  <= cpu_addr;
            io_cmd.fid   <= cpu_fid;
            io_cmd.wr    <= cpu_wr;
            // reads carry no payload; keep the bus quiet
            io_cmd.wdata <= cpu_wr ? PU_WIDTH_NBITS'(cpu_wdata) : '0;
            if (cpu_wr) begin
              r_state <= ST_WR_HOLD;
              r_cnt   <= CNT_WR;
            end else begin
              r_state <= ST_RD_WAIT;
              r_cnt   <= CNT_ZERO;
            end
          end
        end

        ST_RD_WAIT: begin
          // an ack on the final count still wins over the timeout
          if (io_ack) begin
            cpu_rdata  <= io_ack_data;
            cpu_rvalid <= 1'b1;
            r_state    <= ST_IDLE;
            r_cnt      <= CNT_ZERO;
          end else if (r_cnt == CNT_TMO) begin
            cpu_rdata   <= '1;
            cpu_rvalid  <= 1'b1;
            err_timeout <= 1'b1;
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_WR_HOLD: begin
          if (r_cnt == CNT_ZERO) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_io_req_ctrl.sv
// Directed bench for pu_io_req_ctrl with WR_GAP=3, TIMEOUT=8.

module tb_pu_io_req_ctrl;
  import pu_io_req_ctrl_pkg::*;

  localparam int unsigned W = PU_WIDTH_NBITS;

  logic                     clk;
  logic                     rst;
  logic                     cpu_req;
  logic                     cpu_wr;
  logic [IO_ADDR_NBITS-1:0] cpu_addr;
  logic [FID_NBITS-1:0]     cpu_fid;
  logic [W-1:0]             cpu_wdata;
  logic                     cpu_ready;
  logic                     cpu_rvalid;
  logic [W-1:0]             cpu_rdata;
  logic                     io_req;
  io_type                   io_cmd;
  logic                     io_ack;
  logic [W-1:0]             io_ack_data;
  logic                     err_timeout;
  logic                     err_stray_ack;
  logic                     err_proto;

  int total;
  int bad;

  pu_io_req_ctrl #(
    .WIDTH_NBITS (W),
    .WR_GAP      (3),
    .TIMEOUT     (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_wr        (cpu_wr),
    .cpu_addr      (cpu_addr),
    .cpu_fid       (cpu_fid),
    .cpu_wdata     (cpu_wdata),
    .cpu_ready     (cpu_ready),
    .cpu_rvalid    (cpu_rvalid),
    .cpu_rdata     (cpu_rdata),
    .io_req        (io_req),
    .io_cmd        (io_cmd),
    .io_ack        (io_ack),
    .io_ack_data   (io_ack_data),
    .err_timeout   (err_timeout),
    .err_stray_ack (err_stray_ack),
    .err_proto     (err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [15:0] addr, input logic [7:0] fid,
                       input logic [15:0] wdata);
    cpu_req   = 1'b1;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_fid   = fid;
    cpu_wdata = wdata;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    cpu_req     = 1'b0;
    cpu_wr      = 1'b0;
    cpu_addr    = '0;
    cpu_fid     = '0;
    cpu_wdata   = '0;
    io_ack      = 1'b0;
    io_ack_data = '0;

    // reset state
    repeat (3) tick();
    chk("rst_ready",  32'(cpu_ready), 32'd1);
    chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_rdata",  32'(cpu_rdata), 32'd0);
    chk("rst_ioreq",  32'(io_req), 32'd0);
    chk("rst_iocmd",  32'(io_cmd), 32'd0);
    chk("rst_errs",   32'({err_timeout, err_stray_ack, err_proto}), 32'd0);
    rst = 1'b0;
    tick();

    // read with ack 4 cycles after io_req
    issue(1'b0, 16'h0012, 8'd5, 16'hFFFF);
    tick();  // T+1
    cpu_req = 1'b0;
    chk("rd_ioreq",  32'(io_req), 32'd1);
    chk("rd_addr",   32'(io_cmd.addr), 32'h0012);
    chk("rd_fid",    32'(io_cmd.fid), 32'd5);
    chk("rd_wr",     32'(io_cmd.wr), 32'd0);
    chk("rd_wdata0", 32'(io_cmd.wdata), 32'd0);
    chk("rd_ready1", 32'(cpu_ready), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("rd_busy_ready", 32'(cpu_ready), 32'd0);
      chk("rd_busy_ioreq", 32'(io_req), 32'd0);
      chk("rd_busy_rvalid", 32'(cpu_rvalid), 32'd0);
    end
    io_ack      = 1'b1;  // ack in T+5
    io_ack_data = 16'hA5A5;
    tick();  // T+6
    io_ack = 1'b0;
    chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_rdata",  32'(cpu_rdata), 32'hA5A5);
    chk("rd_ready6", 32'(cpu_ready), 32'd1);
    chk("rd_notmo",  32'(err_timeout), 32'd0);
    tick();
    chk("rd_rvalid_pulse", 32'(cpu_rvalid), 32'd0);
    chk("rd_cmd_hold", 32'(io_cmd.addr), 32'h0012);

    // posted write, WR_GAP=3
    issue(1'b1, 16'h0100, 8'd3, 16'h1234);
    tick();  // T+1
    cpu_req = 1'b0;
    chk("wr_ioreq", 32'(io_req), 32'd1);
    chk("wr_wr",    32'(io_cmd.wr), 32'd1);
    chk("wr_wdata", 32'(io_cmd.wdata), 32'h1234);
    chk("wr_addr",  32'(io_cmd.addr), 32'h0100);
    chk("wr_ready1", 32'(cpu_ready), 32'd0);
    tick();  // T+2
    chk("wr_ready2", 32'(cpu_ready), 32'd0);
    chk("wr_ioreq2", 32'(io_req), 32'd0);
    tick();  // T+3
    chk("wr_ready3", 32'(cpu_ready), 32'd0);
    tick();  // T+4
    chk("wr_ready4", 32'(cpu_ready), 32'd1);
    chk("wr_norvalid", 32'(cpu_rvalid), 32'd0);

    // read timeout, TIMEOUT=8, then a late ack
    issue(1'b0, 16'h0200, 8'd7, 16'h0000);
    tick();  // T+1
    cpu_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) tick();
      chk("tmo_wait_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("tmo_wait_ready", 32'(cpu_ready), 32'd0);
    end
    tick();  // T+9
    chk("tmo_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("tmo_rdata",  32'(cpu_rdata), 32'hFFFF);
    chk("tmo_err",    32'(err_timeout), 32'd1);
    chk("tmo_ready",  32'(cpu_ready), 32'd1);
    tick();  // T+10
    chk("tmo_err_pulse", 32'(err_timeout), 32'd0);
    tick();  // T+11
    io_ack      = 1'b1;
    io_ack_data = 16'h5555;
    tick();  // T+12
    io_ack = 1'b0;
    chk("late_stray",  32'(err_stray_ack), 32'd1);
    chk("late_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("late_rdata",  32'(cpu_rdata), 32'hFFFF);
    tick();
    chk("late_stray_pulse", 32'(err_stray_ack), 32'd0);

    // back-to-back reads with ack latency 1
    issue(1'b0, 16'h0010, 8'd1, 16'h0000);
    tick();  // T+1
    cpu_req = 1'b0;
    chk("b2b_ioreq1", 32'(io_req), 32'd1);
    tick();  // T+2
    chk("b2b_ioreq_gap2", 32'(io_req), 32'd0);
    io_ack      = 1'b1;
    io_ack_data = 16'h1111;
    tick();  // T+3
    io_ack = 1'b0;
    chk("b2b_rvalid1", 32'(cpu_rvalid), 32'd1);
    chk("b2b_rdata1",  32'(cpu_rdata), 32'h1111);
    chk("b2b_ioreq_gap3", 32'(io_req), 32'd0);
    issue(1'b0, 16'h0020, 8'd2, 16'h0000);
    tick();  // T+4
    cpu_req = 1'b0;
    chk("b2b_ioreq2", 32'(io_req), 32'd1);
    chk("b2b_addr2",  32'(io_cmd.addr), 32'h0020);
    chk("b2b_noproto", 32'(err_proto), 32'd0);
    tick();  // T+5
    chk("b2b_ioreq_after", 32'(io_req), 32'd0);
    io_ack      = 1'b1;
    io_ack_data = 16'h2222;
    tick();  // T+6
    io_ack = 1'b0;
    chk("b2b_rvalid2", 32'(cpu_rvalid), 32'd1);
    chk("b2b_rdata2",  32'(cpu_rdata), 32'h2222);

    // protocol error during RD_WAIT, then reset mid-transaction
    tick();
    issue(1'b0, 16'h0300, 8'd9, 16'h0000);
    tick();  // T+1
    cpu_req = 1'b0;
    chk("pe_ioreq", 32'(io_req), 32'd1);
    tick();  // T+2
    issue(1'b1, 16'h0444, 8'd4, 16'hBEEF);
    tick();  // T+3
    cpu_req = 1'b0;
    chk("pe_err",   32'(err_proto), 32'd1);
    chk("pe_addr",  32'(io_cmd.addr), 32'h0300);
    chk("pe_wr",    32'(io_cmd.wr), 32'd0);
    chk("pe_ioreq", 32'(io_req), 32'd0);
    chk("pe_ready", 32'(cpu_ready), 32'd0);
    rst = 1'b1;
    #2;
    chk("ar_ready",  32'(cpu_ready), 32'd1);
    chk("ar_ioreq",  32'(io_req), 32'd0);
    chk("ar_proto",  32'(err_proto), 32'd0);
    chk("ar_iocmd",  32'(io_cmd), 32'd0);
    rst = 1'b0;
    tick();
    io_ack      = 1'b1;
    io_ack_data = 16'h7777;
    tick();
    io_ack = 1'b0;
    chk("ar_stray",  32'(err_stray_ack), 32'd1);
    chk("ar_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("ar_tmo",    32'(err_timeout), 32'd0);
    chk("ar_ready2", 32'(cpu_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
